// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel, W-bit arbitrating multiplexer with a one-entry registered
// output stage. Arbitration is round-robin by default, or fixed priority with the
// lowest index winning. Valid/ready handshakes are used on every port.
module rr_mux_n #(
    parameter int N          = 4,
    parameter int W          = 16,
    parameter int FIXED_PRIO = 0,
    parameter int SW         = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic          run_q;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_sel_q;
    logic [SW-1:0] ptr_q;

    logic [N-1:0]  grant;
    logic [SW-1:0] win;
    logic          found;
    logic          slot_free;
    logic          load;
    logic [SW-1:0] ptr_next;

    // Reset-released flag: holds in_ready low for the first cycle after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Grant search: start at ptr (or at 0 in fixed-priority mode), wrap past N-1.
    always_comb begin : arb
        int idx;
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            if (FIXED_PRIO != 0) begin
                idx = k;
            end else begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
            end
            if (!found && in_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = SW'(idx);
            end
        end
    end

    // Handshake and load decision; the slot is free when empty or being drained.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        load      = run_q && slot_free && found;
        in_ready  = grant & {N{slot_free && run_q}};
        ptr_next  = (win == SW'(N - 1)) ? '0 : win + 1'b1;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data[win*W +: W];
            out_sel_q   <= win;
            if (FIXED_PRIO == 0) begin
                ptr_q <= ptr_next;
            end
        end else if (out_ready) begin
            // Drain with no refill: data and index keep their last values.
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
